// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, width helpers and FSM state encoding for the conv1d stage
package cnn_pkg;

    localparam int WIDTH_DATA_DEF   = 16;
    localparam int WIDTH_KERNEL_DEF = 8;

    // Widths for the default configuration; parameterised modules use the helpers below.
    localparam int PROD_W = WIDTH_DATA_DEF + WIDTH_KERNEL_DEF;
    localparam int OUT_W  = WIDTH_DATA_DEF + WIDTH_KERNEL_DEF + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic int prod_w(input int wd, input int wk);
        return wd + wk;
    endfunction

    // Four guard bits cover the sum of up to 16 full-scale products.
    function automatic int out_w(input int wd, input int wk);
        return wd + wk + 4;
    endfunction

endpackage

// File: rtl/conv1d_mac_tree.sv
// rtl/conv1d_mac_tree.sv - registered products (S1) then sign-extended sum, bias and ReLU (S2)
module conv1d_mac_tree
    import cnn_pkg::*;
#(
    parameter int WIDTH_DATA   = WIDTH_DATA_DEF,
    parameter int WIDTH_KERNEL = WIDTH_KERNEL_DEF,
    parameter int KERNEL_SIZE  = 3
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         fire,
    input  logic [KERNEL_SIZE*WIDTH_DATA-1:0]            win,
    input  logic [KERNEL_SIZE*WIDTH_KERNEL-1:0]          taps,
    input  logic [WIDTH_KERNEL-1:0]                      bias,
    output logic                                         valid_o,
    output logic [out_w(WIDTH_DATA, WIDTH_KERNEL)-1:0]   data_o
);

    localparam int WD = WIDTH_DATA;
    localparam int WK = WIDTH_KERNEL;
    localparam int PW = prod_w(WIDTH_DATA, WIDTH_KERNEL);
    localparam int OW = out_w(WIDTH_DATA, WIDTH_KERNEL);

    logic signed [PW-1:0] prod_d [KERNEL_SIZE];
    logic signed [PW-1:0] prod_q [KERNEL_SIZE];
    logic                 s1_valid;
    logic signed [OW-1:0] sum;

    // Operands are sign-extended to the product width so the multiply is exact at PW bits.
    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_mul
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        assign a_ext     = {{WK{win[k*WD+WD-1]}}, win[k*WD +: WD]};
        assign b_ext     = {{WD{taps[k*WK+WK-1]}}, taps[k*WK +: WK]};
        assign prod_d[k] = a_ext * b_ext;
    end

    // S1: capture one product per tap for each fired window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            s1_valid <= fire;
            if (fire) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
        end
    end

    // S2 combinational part: bias plus all products, each widened with guard bits.
    always_comb begin
        sum = {{(OW-WK){bias[WK-1]}}, bias};
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            sum = sum + {{4{prod_q[k][PW-1]}}, prod_q[k]};
        end
    end

    // S2 register: rectify so downstream unsigned compares never see a negative; hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                data_o <= sum[OW-1] ? '0 : sum;
            end
        end
    end

endmodule

// File: rtl/conv1d_11.sv
// rtl/conv1d_11.sv - streaming 1-D convolution with ReLU; optional bias slot under CONV1D_BIAS_EN
module conv1d_11
    import cnn_pkg::*;
#(
    parameter int WIDTH_DATA   = WIDTH_DATA_DEF,
    parameter int WIDTH_KERNEL = WIDTH_KERNEL_DEF,
    parameter int KERNEL_SIZE  = 3
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         valid_i,
    input  logic [WIDTH_DATA-1:0]                        data_i,
    input  logic                                         last_i,
    input  logic                                         w_we,
    input  logic [$clog2(KERNEL_SIZE+1)-1:0]             w_addr,
    input  logic [WIDTH_KERNEL-1:0]                      w_data,
    output logic                                         busy_o,
    output logic                                         err_o,
    output logic                                         valid_o,
    output logic [out_w(WIDTH_DATA, WIDTH_KERNEL)-1:0]   data_o
);

    localparam int AW = $clog2(KERNEL_SIZE+1);
    localparam int CW = $clog2(KERNEL_SIZE+1);
    localparam int WD = WIDTH_DATA;
    localparam int WK = WIDTH_KERNEL;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [KERNEL_SIZE*WD-1:0]     win_q;
    logic [KERNEL_SIZE*WD-1:0]     win_shift;
    logic [KERNEL_SIZE*WK-1:0]     taps_q;
    logic [WK-1:0]                 bias_q;
    logic                          fire;
    logic                          win_clr;
    logic                          err_d;
    logic                          err_q;
    logic                          wr_ok;

    // Newest sample lands in slot 0; slot k is the sample k accepted beats older.
    assign win_shift = {win_q[(KERNEL_SIZE-1)*WD-1:0], data_i};
    assign wr_ok     = (state_q == IDLE) && w_we;
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;

    // Next-state: count samples, fire once the window is full, close the frame on last_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        win_clr = 1'b0;
        err_d   = 1'b0;
        if (valid_i) begin
            fire = (state_q == RUN) || (cnt_q == CW'(KERNEL_SIZE-1));
            if (cnt_q != CW'(KERNEL_SIZE)) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (last_i) begin
                state_d = IDLE;
                cnt_d   = '0;
                win_clr = 1'b1;
                err_d   = !fire;
            end else if (fire) begin
                state_d = RUN;
            end else begin
                state_d = FILL;
            end
        end
    end

    // State, fill count, window and the short-frame error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (valid_i) begin
                win_q <= win_clr ? '0 : win_shift;
            end
        end
    end

    // Taps change only between frames so a frame never mixes coefficient sets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps_q <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                if (w_addr == AW'(k)) begin
                    taps_q[k*WK +: WK] <= w_data;
                end
            end
        end
    end

`ifdef CONV1D_BIAS_EN
    // Bias lives at the slot just past the last tap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bias_q <= '0;
        end else if (wr_ok && (w_addr == AW'(KERNEL_SIZE))) begin
            bias_q <= w_data;
        end
    end
`else
    assign bias_q = '0;
`endif

    conv1d_mac_tree #(
        .WIDTH_DATA   (WIDTH_DATA),
        .WIDTH_KERNEL (WIDTH_KERNEL),
        .KERNEL_SIZE  (KERNEL_SIZE)
    ) u_mac (
        .clk     (clk),
        .rstn    (rstn),
        .fire    (fire),
        .win     (win_shift),
        .taps    (taps_q),
        .bias    (bias_q),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

endmodule

// File: tb/tb_conv1d_11.sv
// tb/tb_conv1d_11.sv - scoreboard bench for conv1d_11 with directed frames
module tb_conv1d_11;
    import cnn_pkg::*;

    localparam int K  = 3;
    localparam int AW = $clog2(K+1);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              valid_i = 1'b0;
    logic [15:0]       data_i = '0;
    logic              last_i = 1'b0;
    logic              w_we = 1'b0;
    logic [AW-1:0]     w_addr = '0;
    logic [7:0]        w_data = '0;
    logic              busy_o;
    logic              err_o;
    logic              valid_o;
    logic [OUT_W-1:0]  data_o;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   dq[$];
    int     eq[$];
    int     vectors = 0;
    int     errors = 0;
    int     cyc = 0;
    longint last_data = 0;

    conv1d_11 #(.WIDTH_DATA(16), .WIDTH_KERNEL(8), .KERNEL_SIZE(K)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (valid_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .busy_o  (busy_o),
        .err_o   (err_o),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a result or an error pulse.
    always @(negedge clk) begin
        if (!rstn) begin
            last_data = 0;
        end else begin
            if (valid_o) begin
                if (dq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_valid: got data_o=%0d, expected no output", data_o);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    check("data_o", longint'(data_o), e.val);
                    check("valid_o_cycle", cyc, e.cyc);
                end
                last_data = longint'(data_o);
            end else begin
                check("data_o_hold", longint'(data_o), last_data);
            end
            if (err_o) begin
                if (eq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_err: got err_o=1, expected 0");
                end else begin
                    check("err_o_cycle", cyc, eq.pop_front());
                end
            end
        end
    end

    // Drive one sample; register the expected result (2 cycles) or error pulse (1 cycle).
    task automatic send(input int d, input bit last, input bit fires, input longint expv);
        valid_i = 1'b1;
        data_i  = d[15:0];
        last_i  = last;
        if (fires) dq.push_back('{val: expv, cyc: cyc + 2});
        if (last && !fires) eq.push_back(cyc + 1);
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic write_tap(input int addr, input int val);
        w_we   = 1'b1;
        w_addr = addr[AW-1:0];
        w_data = val[7:0];
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    task automatic set_taps(input int t0, input int t1, input int t2);
        write_tap(0, t0);
        write_tap(1, t1);
        write_tap(2, t2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid_o", valid_o, 0);
        check("reset_data_o", data_o, 0);
        check("reset_err_o", err_o, 0);
        check("reset_busy_o", busy_o, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic frame: taps {1,2,1}, samples 1..5.
        set_taps(1, 2, 1);
        send(1, 0, 0, 0);
        check("busy_fill", busy_o, 1);
        send(2, 0, 0, 0);
        send(3, 0, 1, 8);
        send(4, 0, 1, 12);
        send(5, 1, 1, 16);
        check("busy_after_last", busy_o, 0);
        repeat (3) @(negedge clk);

        // ReLU clamps a negative sum to zero.
        set_taps(-1, 0, 0);
        send(5, 0, 0, 0);
        send(6, 0, 0, 0);
        send(7, 1, 1, 0);
        repeat (3) @(negedge clk);

        // Short frame errors; next frame (with an idle gap) still produces one output.
        set_taps(1, 2, 1);
        send(10, 0, 0, 0);
        send(20, 1, 0, 0);
        repeat (2) @(negedge clk);
        send(1, 0, 0, 0);
        @(negedge clk);
        send(1, 0, 0, 0);
        send(1, 1, 1, 4);
        repeat (3) @(negedge clk);

        // Tap write during RUN is ignored; the same write in IDLE applies to the next frame.
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 0, 1, 8);
        w_we = 1'b1; w_addr = '0; w_data = 8'd7;
        send(4, 1, 1, 12);
        w_we = 1'b0;
        repeat (3) @(negedge clk);
        write_tap(0, 7);
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 1, 1, 26);
        repeat (3) @(negedge clk);

        // Full-scale negative operands; bias slot applies only when the feature is built in.
        set_taps(-128, -128, -128);
`ifdef CONV1D_BIAS_EN
        write_tap(K, -1);
        send(-32768, 0, 0, 0);
        send(-32768, 0, 0, 0);
        send(-32768, 1, 1, 12582911);
`else
        write_tap(K, 5);
        send(-32768, 0, 0, 0);
        send(-32768, 0, 0, 0);
        send(-32768, 1, 1, 12582912);
`endif
        repeat (3) @(negedge clk);

        // Reset mid-frame discards held samples and taps.
        set_taps(1, 2, 1);
        send(100, 0, 0, 0);
        send(200, 0, 0, 0);
        rstn = 1'b0;
        @(negedge clk);
        check("busy_in_reset", busy_o, 0);
        rstn = 1'b1;
        @(negedge clk);
        set_taps(1, 2, 1);
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 1, 1, 8);

        for (int i = 0; i < 20 && (dq.size() + eq.size()) != 0; i++) @(negedge clk);
        check("scoreboard_drain", dq.size() + eq.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv1d_11.md
Name: conv1d_11

Overview:
- Streaming 1-D convolution stage (stride 1, no padding) placed directly upstream of the 4:1 max-pooling stage.
- Consumes signed samples and runtime-loaded signed kernel taps.
- Emits one rectified accumulator value per full window. Output width is WIDTH_DATA+WIDTH_KERNEL+4, matching the pooling input.
- ReLU is mandatory: the pooling stage compares unsigned, so data_o must never carry a negative value.

Parameters:
- WIDTH_DATA, 16, signed input sample width.
- WIDTH_KERNEL, 8, signed tap width.
- KERNEL_SIZE, 3, number of taps; legal range 2..16, so the sum fits the +4 guard bits.

Ports:
- clk  in  1  clock
- rstn  in  1  async reset, active-low
- valid_i  in  1  data_i valid this cycle
- data_i  in  WIDTH_DATA  signed sample
- last_i  in  1  qualifies the final sample of a frame (sampled only with valid_i)
- w_we  in  1  tap write strobe
- w_addr  in  $clog2(KERNEL_SIZE+1)  tap index; index KERNEL_SIZE is the bias slot (see Optional Feature)
- w_data  in  WIDTH_KERNEL  signed tap value
- busy_o  out  1  high while state is FILL or RUN
- err_o  out  1  one-cycle pulse: frame shorter than KERNEL_SIZE
- valid_o  out  1  data_o valid
- data_o  out  WIDTH_DATA+WIDTH_KERNEL+4  rectified convolution result

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE; window, fill counter, taps and pipeline registers clear.
  - valid_o=0, data_o=0, err_o=0, busy_o=0.
  - Reset mid-frame discards the frame; no outputs follow until a new frame starts.
- Window: shift register of KERNEL_SIZE samples. On valid_i, data_i enters position 0 and the older entries shift. Tap k multiplies window[k], i.e. the sample k cycles older.
- FSM:
  - IDLE: first valid_i loads the sample, sets fill count to 1 and goes to FILL. If KERNEL_SIZE-1 samples are already held, it goes to RUN.
  - FILL: each valid_i increments the fill count. The valid_i that makes count == KERNEL_SIZE fires a window and goes to RUN.
  - RUN: every valid_i fires a window.
  - last_i with valid_i, from any state: that sample is processed normally (it fires if the window is complete). The state then returns to IDLE and the window and count clear.
  - last_i in IDLE or FILL without a completed window: err_o pulses the next cycle and no output is produced.
- valid_i low holds all state; no timeout.
- Pipeline, two stages:
  - S1 registers the KERNEL_SIZE signed products (WIDTH_DATA+WIDTH_KERNEL bits each).
  - S2 sign-extends the products to WIDTH_DATA+WIDTH_KERNEL+4, sums them, applies ReLU (negative becomes 0) and registers the result to data_o.
  - valid_o asserts exactly 2 cycles after the firing valid_i, for 1 cycle.
  - Contiguous valid_i bursts give contiguous valid_o bursts, so the downstream 4-group alignment is preserved.
  - data_o holds its value when valid_o=0.
- Tap writes:
  - Accepted only in IDLE; writes in FILL or RUN are ignored.
  - A write in IDLE takes effect for the next frame.
  - Out-of-range w_addr is ignored.
- Output frame length is N-KERNEL_SIZE+1 for an input frame of N samples.

Optional Feature:
- Macro: CONV1D_BIAS_EN.
- Defined: a bias register is written via w_addr == KERNEL_SIZE. It is sign-extended and added in S2 before ReLU; it resets to 0.
- Undefined: no bias register exists, address KERNEL_SIZE is ignored, and the sum is taps only.

Decomposition:
- Shared package cnn_pkg:
  - width constants: OUT_W = WIDTH_DATA+WIDTH_KERNEL+4, PROD_W = WIDTH_DATA+WIDTH_KERNEL;
  - FSM state enum: IDLE, FILL, RUN.
- One sub-module, conv1d_mac_tree: S1 multipliers plus S2 sign-extending adder and ReLU, with a registered output.
- The FSM, window and tap registers stay in conv1d_11.

Test Plan:
- Basic: taps {1,2,1}; frame 1,2,3,4,5 with last on 5 → valid_o three consecutive cycles, data_o 8,12,16, first valid_o 2 cycles after sample 3.
- ReLU: taps {-1,0,0}; frame 5,6,7 → data_o 0 (one output, valid_o=1).
- Short frame: 2 samples, last on 2nd → no valid_o, err_o pulses once; the next frame of 3 samples yields 1 output.
- Ignored write: during RUN write tap0=7 → results unchanged; the same write in IDLE changes the next frame's results.
- Extreme: taps all -128, samples all -32768, K=3 → data_o = 12582912, no overflow; with CONV1D_BIAS_EN, bias -1 → 12582911.
- Reset mid-frame after 2 samples, then a fresh 3-sample frame → exactly one valid_o, computed from new samples only.
